// File: rtl/execute_single_stage_pkg.sv
// ----------------------------------------------------------------------------
// execute_single_stage_pkg
// Shared types for the execute stage and its neighbours: the decoded
// execute context, the context handed to the memory stage, forwarding and
// HI/LO write records, stage FSM states and exception codes.
// ----------------------------------------------------------------------------
package execute_single_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_LUI,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_LW, OP_SW
    } op_t;

    typedef enum logic [1:0] {SRC_ALU, SRC_HILO, SRC_MEM} src_t;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4} msize_t;
    typedef enum logic {SE_IDLE, SE_DIV} execute_stat_t;

    localparam logic [4:0] EX_OV = 5'h0C;

    typedef struct packed {
        logic       wen;
        logic [4:0] addr;
        src_t       src;
        word_t      value;
    } write_reg_t;

    typedef struct packed {
        logic  wen;
        word_t hi;
        word_t lo;
    } write_hilo_t;

    typedef struct packed {
        logic   valid;
        logic   write;
        msize_t msize;
        word_t  addr;
        word_t  data;
    } memory_args_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
        word_t      epc;
    } exception_t;

    typedef struct packed {
        word_t        pc;
        op_t          op;
        word_t        op1;
        word_t        op2;
        logic [15:0]  imm;
        write_reg_t   write_reg;
        write_hilo_t  write_hilo;
        memory_args_t memory_args;
        exception_t   exception;
        logic         drop;
    } execute_context_t;

    typedef struct packed {
        word_t        pc;
        op_t          op;
        write_reg_t   write_reg;
        write_hilo_t  write_hilo;
        memory_args_t memory_args;
        exception_t   exception;
    } memory_context_t;

    typedef struct packed {
        logic ready;
        logic valid;
    } pipeline_stat_t;

    localparam execute_context_t EXECUTE_CONTEXT_RESET = '0;
    localparam memory_context_t  MEMORY_CONTEXT_RESET  = '0;

    function automatic word_t sign_extend16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/execute_single_stage_divider.sv
// ----------------------------------------------------------------------------
// Execute_Divider
// Radix-2 restoring divider working on operand magnitudes, one quotient bit
// per cycle over 32 cycles. Signs are applied to the final step only, so the
// completed hi/lo appear combinationally during the cycle where last=1.
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset
//   start           : load a, b and begin dividing
//   signed_op       : treat a, b as two's complement (DIV)
//   a, b            : dividend, divisor (divisor must be non-zero)
//   abort           : drop any divide in progress
//   busy            : iterations are in progress
//   last            : this cycle performs the final iteration
//   hi, lo          : remainder, quotient of the current step (valid on last)
// ----------------------------------------------------------------------------
module Execute_Divider
    import execute_single_stage_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  start,
    input  logic  signed_op,
    input  word_t a,
    input  word_t b,
    input  logic  abort,
    output logic  busy,
    output logic  last,
    output word_t hi,
    output word_t lo
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    word_t       rem_q, rem_d;
    word_t       quo_q, quo_d;
    word_t       dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    word_t       a_mag, b_mag;
    logic [32:0] partial, trial;
    word_t       rem_step, quo_step;

    always_comb begin
        a_mag = (signed_op && a[31]) ? -a : a;
        b_mag = (signed_op && b[31]) ? -b : b;

        // Shift the next dividend bit into the remainder and try subtracting.
        partial = {rem_q, quo_q[31]};
        trial   = partial - {1'b0, dvs_q};
        if (!trial[32]) begin
            rem_step = trial[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end else begin
            rem_step = partial[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end

        busy_d    = busy_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = '0;
            dvs_d  = '0;
        end else if (start) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = signed_op && (a[31] ^ b[31]);
            neg_rem_d = signed_op && a[31];
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end

        busy = busy_q;
        last = busy_q && (cnt_q == 5'd31);
        // Quotient negates on differing signs; remainder follows the dividend.
        lo   = neg_quo_q ? -quo_step : quo_step;
        hi   = neg_rem_q ? -rem_step : rem_step;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/execute_single_stage.sv
// ----------------------------------------------------------------------------
// execute_single_stage
// Single-issue execute stage: registers the decoded context, computes ALU,
// load/store address, MULT and DIV results, flags signed overflow, and stalls
// through `done` while the iterative divider runs.
// Ports:
//   clk, resetn             : clock, asynchronous active-low reset
//   decode2execute          : incoming decoded instruction context
//   ExecuteStat             : ready (load new context) / valid (output live)
//   succeed_exception_valid : younger-stage flush, squashes current instruction
//   execute2memory          : context to the memory stage (reset value if dead)
//   write_reg               : forwarding copy of the register result
//   done                    : next state is SE_IDLE
//   busy_div                : current state is SE_DIV
//   exception_valid         : current instruction carries an exception
// ----------------------------------------------------------------------------
module execute_single_stage
    import execute_single_stage_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  execute_context_t decode2execute,
    input  pipeline_stat_t   ExecuteStat,
    input  logic             succeed_exception_valid,
    output memory_context_t  execute2memory,
    output write_reg_t       write_reg,
    output logic             done,
    output logic             busy_div,
    output logic             exception_valid
);

    execute_stat_t    state_q, state_d;
    execute_context_t ctx_q, ctx_d;

    logic            div_start, div_abort, div_busy, div_last;
    word_t           div_hi, div_lo;
    word_t           imm_sext, op2_eff, sum, diff, alu_result;
    logic [63:0]     mul_a, mul_b, product;
    logic            mul_signed, overflow, live;
    memory_context_t res;

    // A divide only runs for a clean instruction with a non-zero divisor;
    // divide-by-zero resolves combinationally in the idle state instead.
    always_comb begin
        div_start = ExecuteStat.ready
                 && (decode2execute.op inside {OP_DIV, OP_DIVU})
                 && !decode2execute.exception.valid
                 && !decode2execute.drop
                 && (decode2execute.op2 != '0);
        div_abort = succeed_exception_valid
                 || (ExecuteStat.ready && !div_start && div_busy);
    end

    Execute_Divider u_divider (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (decode2execute.op == OP_DIV),
        .a         (decode2execute.op1),
        .b         (decode2execute.op2),
        .abort     (div_abort),
        .busy      (div_busy),
        .last      (div_last),
        .hi        (div_hi),
        .lo        (div_lo)
    );

    // Results of the registered instruction.
    always_comb begin
        imm_sext = sign_extend16(ctx_q.imm);
        op2_eff  = (ctx_q.op inside {OP_ADDI, OP_ADDIU}) ? imm_sext : ctx_q.op2;
        sum      = ctx_q.op1 + op2_eff;
        diff     = ctx_q.op1 - ctx_q.op2;

        mul_signed = (ctx_q.op == OP_MULT);
        mul_a      = {{32{mul_signed & ctx_q.op1[31]}}, ctx_q.op1};
        mul_b      = {{32{mul_signed & ctx_q.op2[31]}}, ctx_q.op2};
        product    = mul_a * mul_b;

        unique case (ctx_q.op)
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: alu_result = sum;
            OP_SUB, OP_SUBU: alu_result = diff;
            OP_AND:  alu_result = ctx_q.op1 & ctx_q.op2;
            OP_OR:   alu_result = ctx_q.op1 | ctx_q.op2;
            OP_XOR:  alu_result = ctx_q.op1 ^ ctx_q.op2;
            OP_NOR:  alu_result = ~(ctx_q.op1 | ctx_q.op2);
            OP_SLT:  alu_result = {31'b0, $signed(ctx_q.op1) < $signed(ctx_q.op2)};
            OP_SLTU: alu_result = {31'b0, ctx_q.op1 < ctx_q.op2};
            OP_SLL:  alu_result = ctx_q.op2 << ctx_q.op1[4:0];
            OP_SRL:  alu_result = ctx_q.op2 >> ctx_q.op1[4:0];
            OP_SRA:  alu_result = word_t'($signed(ctx_q.op2) >>> ctx_q.op1[4:0]);
            OP_LUI:  alu_result = {ctx_q.imm, 16'h0000};
            default: alu_result = '0;
        endcase

        overflow = 1'b0;
        if (ctx_q.op inside {OP_ADD, OP_ADDI}) begin
            overflow = (ctx_q.op1[31] == op2_eff[31]) && (sum[31] != ctx_q.op1[31]);
        end else if (ctx_q.op == OP_SUB) begin
            overflow = (ctx_q.op1[31] != ctx_q.op2[31]) && (diff[31] != ctx_q.op1[31]);
        end

        res.pc          = ctx_q.pc;
        res.op          = ctx_q.op;
        res.write_reg   = ctx_q.write_reg;
        res.write_hilo  = ctx_q.write_hilo;
        res.memory_args = ctx_q.memory_args;
        res.exception   = ctx_q.exception;

        // Faulted or dropped instructions pass through untouched.
        if (!ctx_q.exception.valid && !ctx_q.drop) begin
            if (ctx_q.write_reg.src == SRC_ALU) begin
                res.write_reg.value = alu_result;
            end
            if (ctx_q.memory_args.valid) begin
                res.memory_args.addr = ctx_q.op1 + imm_sext;
            end
            if (ctx_q.op inside {OP_MULT, OP_MULTU}) begin
                res.write_hilo.hi = product[63:32];
                res.write_hilo.lo = product[31:0];
            end else if (ctx_q.op inside {OP_DIV, OP_DIVU}) begin
                // After completion the result lives in ctx_q.write_hilo.
                if (ctx_q.op2 == '0) begin
                    res.write_hilo.hi = ctx_q.op1;
                    res.write_hilo.lo = 32'hFFFF_FFFF;
                end else if (state_q == SE_DIV) begin
                    res.write_hilo.hi = div_hi;
                    res.write_hilo.lo = div_lo;
                end
            end
            if (overflow) begin
                res.exception.valid = 1'b1;
                res.exception.code  = EX_OV;
                res.exception.epc   = ctx_q.pc;
                res.write_reg.wen   = 1'b0;
            end
        end

        // A flush in this very cycle already kills the output.
        live            = ExecuteStat.valid && !ctx_q.drop && !succeed_exception_valid;
        execute2memory  = live ? res : MEMORY_CONTEXT_RESET;
        write_reg       = live ? res.write_reg : '0;
        exception_valid = res.exception.valid && !ctx_q.drop;
    end

    // Next state: a flush beats everything, then a new capture, then the
    // divider finishing, whose result is parked in the context for holding.
    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        if (succeed_exception_valid) begin
            state_d    = SE_IDLE;
            ctx_d.drop = 1'b1;
        end else if (ExecuteStat.ready) begin
            ctx_d   = decode2execute;
            state_d = div_start ? SE_DIV : SE_IDLE;
        end else if ((state_q == SE_DIV) && div_last) begin
            state_d             = SE_IDLE;
            ctx_d.write_hilo.hi = div_hi;
            ctx_d.write_hilo.lo = div_lo;
        end
        done     = (state_d == SE_IDLE);
        busy_div = (state_q == SE_DIV);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SE_IDLE;
            ctx_q   <= EXECUTE_CONTEXT_RESET;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
        end
    end

endmodule

// File: tb/tb_execute_single_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_single_stage
// Directed vectors for the execute stage. The driver issues one instruction at
// a time and queues its hand-computed result; an independent monitor pops and
// compares whenever the stage shows a live, completed output.
// ----------------------------------------------------------------------------
module tb_execute_single_stage;
    import execute_single_stage_pkg::*;

    logic             clk = 1'b0;
    logic             resetn;
    execute_context_t decode2execute;
    pipeline_stat_t   exec_stat;
    logic             squash;
    memory_context_t  execute2memory;
    write_reg_t       wreg_o;
    logic             done, busy_div, exception_valid;

    typedef struct {
        memory_context_t exp;
        logic            exc;
        int              busy;
    } item_t;

    item_t expq[$];
    string nameq[$];
    int    checks   = 0;
    int    failures = 0;
    int    busy_cnt = 0;
    word_t pc_ctr   = 32'h0000_0100;

    execute_single_stage dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .decode2execute          (decode2execute),
        .ExecuteStat             (exec_stat),
        .succeed_exception_valid (squash),
        .execute2memory          (execute2memory),
        .write_reg               (wreg_o),
        .done                    (done),
        .busy_div                (busy_div),
        .exception_valid         (exception_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count divider-busy cycles and check each completed output.
    always @(negedge clk) begin
        item_t it;
        string nm;
        if (!resetn) begin
            busy_cnt = 0;
        end else begin
            if (busy_div) busy_cnt++;
            if (exec_stat.valid && done && expq.size() > 0) begin
                it = expq.pop_front();
                nm = nameq.pop_front();
                checkOutput({nm, ".ctx"},  execute2memory,  it.exp);
                checkOutput({nm, ".wreg"}, wreg_o,          it.exp.write_reg);
                checkOutput({nm, ".excv"}, exception_valid, it.exc);
                checkOutput({nm, ".busy"}, busy_cnt,        it.busy);
                busy_cnt = 0;
            end
        end
    end

    function automatic execute_context_t mkCtx(input word_t pc, input op_t op, input word_t a,
                                               input word_t b, input logic [15:0] imm);
        execute_context_t c;
        c                   = EXECUTE_CONTEXT_RESET;
        c.pc                = pc;
        c.op                = op;
        c.op1               = a;
        c.op2               = b;
        c.imm               = imm;
        c.write_reg.wen     = 1'b1;
        c.write_reg.addr    = 5'd2;
        c.write_reg.src     = SRC_ALU;
        return c;
    endfunction

    // Fields the stage never alters are carried straight across.
    function automatic memory_context_t passExp(input execute_context_t c);
        memory_context_t e;
        e             = MEMORY_CONTEXT_RESET;
        e.pc          = c.pc;
        e.op          = c.op;
        e.write_reg   = c.write_reg;
        e.write_hilo  = c.write_hilo;
        e.memory_args = c.memory_args;
        e.exception   = c.exception;
        return e;
    endfunction

    task automatic applyStimulus(input execute_context_t ctx, input memory_context_t exp,
                                 input logic exp_exc, input int exp_busy, input string name,
                                 input int squash_at);
        item_t it;
        @(posedge clk); #1;
        decode2execute  = ctx;
        exec_stat.ready = 1'b1;
        exec_stat.valid = 1'b0;
        @(posedge clk); #1;
        exec_stat.ready = 1'b0;
        exec_stat.valid = 1'b1;
        it.exp  = exp;
        it.exc  = exp_exc;
        it.busy = exp_busy;
        expq.push_back(it);
        nameq.push_back(name);
        pc_ctr += 32'd4;
        for (int c = 1; c < 200 && expq.size() > 0; c++) begin
            if (c == squash_at) squash = 1'b1;
            @(posedge clk); #1;
            squash = 1'b0;
        end
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.timeout: got no output expected one within 200 cycles", name);
            void'(expq.pop_front());
            void'(nameq.pop_front());
        end
        exec_stat.valid = 1'b0;
    endtask

    task automatic aluCase(input op_t op, input word_t a, input word_t b, input logic [15:0] imm,
                           input word_t value, input string name);
        execute_context_t c;
        memory_context_t  e;
        c = mkCtx(pc_ctr, op, a, b, imm);
        e = passExp(c);
        e.write_reg.value = value;
        applyStimulus(c, e, 1'b0, 0, name, 0);
    endtask

    task automatic ovfCase(input op_t op, input word_t a, input word_t b, input logic [15:0] imm,
                           input word_t value, input string name);
        execute_context_t c;
        memory_context_t  e;
        c = mkCtx(pc_ctr, op, a, b, imm);
        e = passExp(c);
        e.write_reg.value = value;
        e.write_reg.wen   = 1'b0;
        e.exception.valid = 1'b1;
        e.exception.code  = EX_OV;
        e.exception.epc   = c.pc;
        applyStimulus(c, e, 1'b1, 0, name, 0);
    endtask

    task automatic hiloCase(input op_t op, input word_t a, input word_t b, input word_t hi,
                            input word_t lo, input int busy, input string name);
        execute_context_t c;
        memory_context_t  e;
        c = mkCtx(pc_ctr, op, a, b, 16'h0000);
        c.write_reg.wen  = 1'b0;
        c.write_hilo.wen = 1'b1;
        e = passExp(c);
        e.write_hilo.hi = hi;
        e.write_hilo.lo = lo;
        applyStimulus(c, e, 1'b0, busy, name, 0);
    endtask

    initial begin
        execute_context_t c;
        memory_context_t  e;
        decode2execute = EXECUTE_CONTEXT_RESET;
        exec_stat      = '0;
        squash         = 1'b0;
        resetn         = 1'b0;
        #2;
        checkOutput("reset.done", done, 1'b1);
        checkOutput("reset.busy", busy_div, 1'b0);
        checkOutput("reset.excv", exception_valid, 1'b0);
        checkOutput("reset.ctx", execute2memory, MEMORY_CONTEXT_RESET);
        @(posedge clk); #1;
        resetn = 1'b1;

        $display("[TB] ALU and overflow vectors");
        ovfCase(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 32'h8000_0000, "add_ovf");
        aluCase(OP_ADDU, 32'h0000_0003, 32'h0000_0004, 16'h0000, 32'h0000_0007, "addu");
        aluCase(OP_SUB,  32'h0000_0005, 32'h0000_0008, 16'h0000, 32'hFFFF_FFFD, "sub");
        ovfCase(OP_SUB,  32'h8000_0000, 32'h0000_0001, 16'h0000, 32'h7FFF_FFFF, "sub_ovf");
        ovfCase(OP_ADDI, 32'h7FFF_FFF0, 32'h0000_0000, 16'h0010, 32'h8000_0000, "addi_ovf");
        aluCase(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0000, 32'h00F0_00F0, "and");
        aluCase(OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0000, 32'hFFF0_FFF0, "or");
        aluCase(OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0000, 32'hFF00_FF00, "xor");
        aluCase(OP_NOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0000, 32'h000F_000F, "nor");
        aluCase(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 16'h0000, 32'h0000_0001, "slt");
        aluCase(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0000, 32'h0000_0000, "sltu");
        aluCase(OP_SLL,  32'h0000_0004, 32'h0000_0001, 16'h0000, 32'h0000_0010, "sll");
        aluCase(OP_SRL,  32'h0000_0004, 32'h8000_0000, 16'h0000, 32'h0800_0000, "srl");
        aluCase(OP_SRA,  32'h0000_0004, 32'h8000_0000, 16'h0000, 32'hF800_0000, "sra");
        aluCase(OP_LUI,  32'h0000_0000, 32'h0000_0000, 16'h1234, 32'h1234_0000, "lui");

        $display("[TB] multiply and divide vectors");
        hiloCase(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0,  "mult");
        hiloCase(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0,  "multu");
        hiloCase(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, "div_m7_2");
        hiloCase(OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 32, "divu_100_7");
        hiloCase(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 32, "div_7_m2");
        hiloCase(OP_DIVU,  32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFF, 0,  "divu_by0");

        $display("[TB] load/store vectors");
        c = mkCtx(pc_ctr, OP_LW, 32'h0000_1000, 32'h0, 16'hFFFC);
        c.write_reg.src     = SRC_MEM;
        c.write_reg.addr    = 5'd8;
        c.memory_args.valid = 1'b1;
        c.memory_args.msize = MSIZE4;
        e = passExp(c);
        e.memory_args.addr  = 32'h0000_0FFC;
        applyStimulus(c, e, 1'b0, 0, "lw", 0);

        c = mkCtx(pc_ctr, OP_SW, 32'h0000_2000, 32'hDEAD_BEEF, 16'h0008);
        c.write_reg         = '0;
        c.memory_args.valid = 1'b1;
        c.memory_args.write = 1'b1;
        c.memory_args.msize = MSIZE4;
        c.memory_args.data  = 32'hDEAD_BEEF;
        e = passExp(c);
        e.memory_args.addr  = 32'h0000_2008;
        applyStimulus(c, e, 1'b0, 0, "sw", 0);

        $display("[TB] incoming exception, drop and squash");
        c = mkCtx(pc_ctr, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0000);
        c.exception.valid = 1'b1;
        c.exception.code  = 5'h04;
        c.exception.epc   = c.pc;
        e = passExp(c);
        applyStimulus(c, e, 1'b1, 0, "exc_pass", 0);

        c = mkCtx(pc_ctr, OP_ADDU, 32'h0000_0003, 32'h0000_0004, 16'h0000);
        c.drop = 1'b1;
        applyStimulus(c, MEMORY_CONTEXT_RESET, 1'b0, 0, "drop", 0);

        c = mkCtx(pc_ctr, OP_DIV, 32'h0000_0064, 32'h0000_0003, 16'h0000);
        c.write_reg.wen  = 1'b0;
        c.write_hilo.wen = 1'b1;
        applyStimulus(c, MEMORY_CONTEXT_RESET, 1'b0, 10, "squash", 10);
        checkOutput("squash.after_busy", busy_div, 1'b0);
        checkOutput("squash.after_done", done, 1'b1);
        checkOutput("squash.after_ctx", execute2memory, MEMORY_CONTEXT_RESET);

        $display("[TB] reset during divide");
        @(posedge clk); #1;
        decode2execute  = c;
        exec_stat.ready = 1'b1;
        @(posedge clk); #1;
        exec_stat.ready = 1'b0;
        exec_stat.valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_mid.busy_before", busy_div, 1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid.done", done, 1'b1);
        checkOutput("rst_mid.busy", busy_div, 1'b0);
        checkOutput("rst_mid.excv", exception_valid, 1'b0);
        checkOutput("rst_mid.ctx", execute2memory, MEMORY_CONTEXT_RESET);
        @(posedge clk); #1;
        resetn          = 1'b1;
        exec_stat.valid = 1'b0;
        aluCase(OP_ADDU, 32'h0000_0003, 32'h0000_0004, 16'h0000, 32'h0000_0007, "addu_after_rst");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
